// File: rtl/bcd_conv_seq.sv
// ---------------------------------------------------------------------------
// bcd_conv_seq
//
// Multi-cycle binary-to-BCD converter built on the double-dabble algorithm.
// It processes one binary bit per clock, so W bits take W cycles. This keeps
// the logic per clock to a single add-3 stage per digit. A long combinational
// chain is not needed.
// Both sides use a valid/ready handshake. Only one conversion is in flight
// at a time.
//
// Parameters
//   W            binary input width (>= 4)
//   ND           number of BCD digits produced (10**ND >= 2**W)
//
// Ports
//   clk          in   1              system clock, rising edge
//   rst          in   1              asynchronous active-high reset
//   clr          in   1              synchronous abort back to IDLE
//   in_valid     in   1              in_data is valid
//   in_ready     out  1              converter can accept (IDLE)
//   in_data      in   W              unsigned binary value
//   out_valid    out  1              out_bcd / out_ndigits hold a result
//   out_ready    in   1              consumer accepts the result
//   out_bcd      out  4*ND           packed BCD, digit 0 in bits [3:0]
//   out_ndigits  out  $clog2(ND+1)   significant digit count, 1..ND
//   busy         out  1              converter is not IDLE
// ---------------------------------------------------------------------------
module bcd_conv_seq #(
    parameter int W  = 32,
    parameter int ND = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*ND-1:0]           out_bcd,
    output logic [$clog2(ND+1)-1:0]   out_ndigits,
    output logic                      busy
);

    localparam int CW = $clog2(W + 1);
    localparam int NW = $clog2(ND + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [W-1:0]      bin_q;
    logic [4*ND-1:0]   bcd_q;
    logic [CW-1:0]     cnt_q;

    logic [4*ND-1:0]   bcd_adj;
    logic [W-1:0]      bin_d;
    logic [4*ND-1:0]   bcd_d;

    logic              accept;
    logic              last_iter;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = bcd_q;

    assign accept    = in_ready && in_valid;
    assign last_iter = (cnt_q == CW'(W - 1));

    // Add-3 correction. Every digit is at most 9 here, so a digit of 5..9
    // becomes 8..12. That still fits in 4 bits, and no carry crosses into
    // the next digit.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < ND; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end else begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
            end
        end
    end

    // The corrected digits and the binary register shift left together as
    // one wide register. The binary MSB enters BCD bit 0. The top corrected
    // bit falls off, and it is always zero for a correctly sized ND.
    assign {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;

    // Significant digit count: the position of the highest nonzero digit
    // plus one. An all-zero value still reports one digit.
    always_comb begin
        out_ndigits = NW'(1);
        for (int i = 0; i < ND; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                out_ndigits = NW'(i + 1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. clr overrides every transition, including an accept
    // in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clr) begin
            state_d = IDLE;
        end
    end

    // Datapath registers.
    // - The counter holds at W-1 on the final iteration and never wraps.
    // - In DONE and after the handshake, the BCD register keeps its value
    //   until the next accept clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bin_q <= in_data;
                        bcd_q <= '0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_d;
                    bcd_q <= bcd_d;
                    if (!last_iter) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_seq.sv
// ---------------------------------------------------------------------------
// tb_bcd_conv_seq
//
// Self-checking bench for bcd_conv_seq (W=32, ND=10).
// - When a value is handed to the converter, its expected BCD result and
//   digit count go into a scoreboard queue.
// - When out_valid rises, the oldest entry is popped and compared.
// - Inputs are driven 1 ns after the rising edge, and outputs are sampled
//   at the same point.
// ---------------------------------------------------------------------------
module tb_bcd_conv_seq;

    localparam int W  = 32;
    localparam int ND = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic              out_valid;
    logic              out_ready;
    logic [4*ND-1:0]   out_bcd;
    logic [3:0]        out_ndigits;
    logic              busy;

    typedef struct packed {
        logic [4*ND-1:0] bcd;
        logic [3:0]      nd;
    } exp_t;

    exp_t sbQ[$];
    exp_t lastExp;

    int total = 0;
    int bad   = 0;

    bcd_conv_seq #(.W(W), .ND(ND)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bcd     (out_bcd),
        .out_ndigits (out_ndigits),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends, even if the converter locks up.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the decimal digits come from repeated division by 10.
    function automatic exp_t model(input logic [W-1:0] v);
        exp_t        e;
        longint      t;
        e.bcd = '0;
        e.nd  = 4'd1;
        t     = longint'(v);
        for (int i = 0; i < ND; i++) begin
            e.bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        t = longint'(v);
        while (t >= 10) begin
            t = t / 10;
            e.nd = e.nd + 4'd1;
        end
        return e;
    endfunction

    // Wait for in_ready, present the value for one accept edge, then push
    // the expected result to the scoreboard.
    task automatic applyStimulus(input logic [W-1:0] value, input exp_t e);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            stepClk();
            w++;
        end
        if (!in_ready) checkOutput("accept_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = value;
        stepClk();
        in_valid = 1'b0;
        in_data  = $urandom;
        sbQ.push_back(e);
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
        checkOutput("in_ready_shift", 64'(in_ready), 64'd0);
    endtask

    // Called 1 ns after the accept edge. Counts edges until out_valid rises,
    // then checks the latency and the result against the scoreboard.
    task automatic waitResult(input string tag);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            stepClk();
            cycles++;
        end
        checkOutput({tag, "_latency"}, 64'(cycles), 64'(W));
        if (sbQ.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sbQ.pop_front();
            lastExp = e;
            checkOutput({tag, "_bcd"}, 64'(out_bcd), 64'(e.bcd));
            checkOutput({tag, "_nd"}, 64'(out_ndigits), 64'(e.nd));
            checkOutput({tag, "_busy_done"}, 64'(busy), 64'd1);
        end
    endtask

    // Perform the output handshake and check the return to IDLE with the
    // result retained.
    task automatic handshake(input string tag);
        out_ready = 1'b1;
        stepClk();
        out_ready = 1'b0;
        checkOutput({tag, "_ov_low"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_retained"}, 64'(out_bcd), 64'(lastExp.bcd));
    endtask

    task automatic convert(input string tag, input logic [W-1:0] v, input exp_t e);
        applyStimulus(v, e);
        waitResult(tag);
        handshake(tag);
    endtask

    initial begin
        exp_t e;
        logic [W-1:0] r;
        bit   sawValid;

        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_bcd", 64'(out_bcd), 64'd0);
        checkOutput("rst_ndigits", 64'(out_ndigits), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Main value and corners, using constants worked out by hand.
        e.bcd = 40'h1234567890; e.nd = 4'd10;
        convert("v1234567890", 32'd1234567890, e);
        e.bcd = 40'h0;          e.nd = 4'd1;
        convert("zero", 32'd0, e);
        e.bcd = 40'h4294967295; e.nd = 4'd10;
        convert("allones", 32'hFFFFFFFF, e);
        e.bcd = 40'h9;          e.nd = 4'd1;
        convert("nine", 32'd9, e);
        e.bcd = 40'h10;         e.nd = 4'd2;
        convert("ten", 32'd10, e);

        // Random values checked against the reference model.
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            convert("random", r, model(r));
        end

        // Backpressure: the result must hold, and the new data waits.
        e.bcd = 40'h4242; e.nd = 4'd4;
        applyStimulus(32'd4242, e);
        waitResult("bp_first");
        in_valid = 1'b1;
        in_data  = 32'd31337;
        for (int i = 0; i < 5; i++) begin
            stepClk();
            checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
            checkOutput("bp_out_bcd", 64'(out_bcd), 64'(lastExp.bcd));
        end
        out_ready = 1'b1;
        stepClk();
        out_ready = 1'b0;
        checkOutput("bp_hs_idle", 64'(busy), 64'd0);
        checkOutput("bp_hs_ready", 64'(in_ready), 64'd1);
        stepClk();
        in_valid = 1'b0;
        in_data  = $urandom;
        e.bcd = 40'h31337; e.nd = 4'd5;
        sbQ.push_back(e);
        checkOutput("bp_second_busy", 64'(busy), 64'd1);
        waitResult("bp_second");
        handshake("bp_second");

        // clr mid-conversion: the result must never appear.
        in_valid = 1'b1;
        in_data  = 32'd777;
        stepClk();
        in_valid = 1'b0;
        repeat (10) stepClk();
        checkOutput("clr_busy_before", 64'(busy), 64'd1);
        clr = 1'b1;
        stepClk();
        clr = 1'b0;
        checkOutput("clr_busy", 64'(busy), 64'd0);
        checkOutput("clr_in_ready", 64'(in_ready), 64'd1);
        checkOutput("clr_out_bcd", 64'(out_bcd), 64'd0);
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) sawValid = 1'b1;
            stepClk();
        end
        checkOutput("clr_no_valid", 64'(sawValid), 64'd0);
        e.bcd = 40'h255; e.nd = 4'd3;
        convert("after_clr", 32'd255, e);

        // Asynchronous reset pulse between edges during SHIFT.
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        stepClk();
        in_valid = 1'b0;
        repeat (8) stepClk();
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("arst_out_bcd", 64'(out_bcd), 64'd0);
        checkOutput("arst_ndigits", 64'(out_ndigits), 64'd1);
        #1;
        rst = 1'b0;
        stepClk();
        e.bcd = 40'h1000; e.nd = 4'd4;
        convert("after_rst", 32'd1000, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
